dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Wait-state data memory responder: 16-bit word array behind a cyc/stb/ack handshake.
// Optional out-of-range error reporting is enabled by defining DMEM_RESP_ERR_EN.
module dmem_responder #(
    parameter int unsigned DEPTH_LOG2  = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dmem_action_cyc,
    input  logic        dmem_action_stb,
    input  logic        dmem_write,
    input  logic [1:0]  dmem_byte_enable,
    input  logic [15:0] dmem_address,
    input  logic [15:0] dmem_wdata,
    output logic        dmem_resp,
    output logic [15:0] dmem_rdata
`ifdef DMEM_RESP_ERR_EN
    ,
    output logic        dmem_err
`endif
);

    localparam int unsigned WORDS = 1 << DEPTH_LOG2;
    localparam logic [3:0] COUNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t                state;
    logic [3:0]            count;
    logic                  write_q;
    logic [1:0]            be_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [15:0]           wdata_q;
    logic                  oor_q;

    logic [15:0]           mem [WORDS];

    logic [DEPTH_LOG2-1:0] req_idx;
    logic                  req_oor;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic                  rd_write;
    logic                  rd_oor;
    logic                  unused_addr;

    assign req_idx     = dmem_address[DEPTH_LOG2:1];
    assign unused_addr = ^dmem_address;

`ifdef DMEM_RESP_ERR_EN
    assign req_oor = (32'(dmem_address[15:1]) >= WORDS);
`else
    assign req_oor = 1'b0;
`endif

    // With zero wait cycles the response is built in the same edge that accepts the
    // request, so the read source must bypass the not-yet-valid request latches.
    always_comb begin
        rd_idx   = idx_q;
        rd_write = write_q;
        rd_oor   = oor_q;
        if (state == IDLE) begin
            rd_idx   = req_idx;
            rd_write = dmem_write;
            rd_oor   = req_oor;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            dmem_resp  <= 1'b0;
            dmem_rdata <= '0;
            write_q    <= 1'b0;
            be_q       <= '0;
            idx_q      <= '0;
            wdata_q    <= '0;
            oor_q      <= 1'b0;
`ifdef DMEM_RESP_ERR_EN
            dmem_err   <= 1'b0;
`endif
        end else begin
            dmem_resp  <= 1'b0;
            dmem_rdata <= '0;
`ifdef DMEM_RESP_ERR_EN
            dmem_err   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (dmem_action_cyc && dmem_action_stb) begin
                        write_q <= dmem_write;
                        be_q    <= dmem_byte_enable;
                        idx_q   <= req_idx;
                        wdata_q <= dmem_wdata;
                        oor_q   <= req_oor;
                        if (WAIT_CYCLES == 0) begin
                            state      <= RESP;
                            dmem_resp  <= 1'b1;
                            dmem_rdata <= (rd_write || rd_oor) ? 16'h0000 : mem[rd_idx];
`ifdef DMEM_RESP_ERR_EN
                            dmem_err   <= rd_oor;
`endif
                        end else begin
                            state <= WAIT;
                            count <= COUNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (!dmem_action_cyc) begin
                        state <= IDLE;
                        count <= '0;
                    end else if (count == 4'd0) begin
                        state      <= RESP;
                        dmem_resp  <= 1'b1;
                        dmem_rdata <= (rd_write || rd_oor) ? 16'h0000 : mem[rd_idx];
`ifdef DMEM_RESP_ERR_EN
                        dmem_err   <= rd_oor;
`endif
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Stores commit on the edge that leaves RESP, so a reset sampled there drops them.
    always_ff @(posedge clk) begin
        if (!rst && state == RESP && write_q && !oor_q) begin
            if (be_q[0]) mem[idx_q][7:0]  <= wdata_q[7:0];
            if (be_q[1]) mem[idx_q][15:8] <= wdata_q[15:8];
        end
    end

endmodule
